// File: rtl/bigmul_operand_loader_if.sv
// Operand-loader bus: limb stream in, limb-array write port and multiplier
// start/done handshake out.
//   master : loader side (drives in_ready, wr_*, mul_start, job_done)
//   slave  : environment side (drives in_valid/in_data/in_last, mul_busy/mul_done)
interface bigmul_operand_loader_if #(
  parameter int unsigned NUM_LIMBS = 64,
  parameter int unsigned LIMB_W    = 64
);
  localparam int unsigned IDX_W = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;

  logic              in_valid;
  logic              in_ready;
  logic [LIMB_W-1:0] in_data;
  logic              in_last;

  logic              wr_en;
  logic              wr_sel;
  logic [IDX_W-1:0]  wr_idx;
  logic [LIMB_W-1:0] wr_data;

  logic              mul_start;
  logic              mul_busy;
  logic              mul_done;
  logic              job_done;

  modport master (
    input  in_valid, in_data, in_last, mul_busy, mul_done,
    output in_ready, wr_en, wr_sel, wr_idx, wr_data, mul_start, job_done
  );

  modport slave (
    output in_valid, in_data, in_last, mul_busy, mul_done,
    input  in_ready, wr_en, wr_sel, wr_idx, wr_data, mul_start, job_done
  );
endinterface

// File: rtl/bigmul_operand_loader.sv
// Feeds bigmul_unit_csa: streams operand A then B limbs (LS limb first) into
// the multiplier limb arrays, zero-pads short operands, pulses mul_start and
// waits for mul_done before reporting job_done and accepting the next job.
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus_io     : loader bus (stream in, limb write port, start/done handshake)
module bigmul_operand_loader #(
  parameter int unsigned NUM_LIMBS = 64,
  parameter int unsigned LIMB_W    = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  bigmul_operand_loader_if.master bus_io
);
  localparam int unsigned IDX_W = (NUM_LIMBS > 1) ? $clog2(NUM_LIMBS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LIMBS - 1);

  typedef enum logic [2:0] {
    S_LOAD_A,
    S_PAD_A,
    S_LOAD_B,
    S_PAD_B,
    S_FIRE,
    S_WAIT
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic              wr_sel_q, wr_sel_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [LIMB_W-1:0] wr_data_q, wr_data_d;
  logic              mul_start_q, mul_start_d;
  logic              job_done_q, job_done_d;
  logic              accept_c;

  assign accept_c = bus_io.in_valid && in_ready_q;

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LOAD_A;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_sel_q    <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
      mul_start_q <= 1'b0;
      job_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      wr_en_q     <= wr_en_d;
      wr_sel_q    <= wr_sel_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
      mul_start_q <= mul_start_d;
      job_done_q  <= job_done_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_en_d     = 1'b0;
    wr_sel_d    = wr_sel_q;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    mul_start_d = 1'b0;
    job_done_d  = 1'b0;

    case (state_q)
      S_LOAD_A, S_LOAD_B: begin
        if (accept_c) begin
          wr_en_d   = 1'b1;
          wr_sel_d  = (state_q == S_LOAD_B);
          wr_idx_d  = idx_q;
          wr_data_d = bus_io.in_data;
          // The top limb closes the operand whether or not in_last is set.
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = (state_q == S_LOAD_A) ? S_LOAD_B : S_FIRE;
          end else begin
            idx_d = idx_q + IDX_W'(1);
            if (bus_io.in_last) begin
              state_d = (state_q == S_LOAD_A) ? S_PAD_A : S_PAD_B;
            end
          end
        end
      end

      S_PAD_A, S_PAD_B: begin
        wr_en_d   = 1'b1;
        wr_sel_d  = (state_q == S_PAD_B);
        wr_idx_d  = idx_q;
        wr_data_d = '0;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = (state_q == S_PAD_A) ? S_LOAD_B : S_FIRE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      // The final write is already on the port while in FIRE, so the
      // registered start lands one cycle after it at the earliest.
      S_FIRE: begin
        if (!bus_io.mul_busy) begin
          mul_start_d = 1'b1;
          state_d     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (bus_io.mul_done) begin
          job_done_d = 1'b1;
          idx_d      = '0;
          state_d    = S_LOAD_A;
        end
      end

      default: begin
        state_d = S_LOAD_A;
        idx_d   = '0;
      end
    endcase

    in_ready_d = (state_d == S_LOAD_A) || (state_d == S_LOAD_B);
  end

  assign bus_io.in_ready  = in_ready_q;
  assign bus_io.wr_en     = wr_en_q;
  assign bus_io.wr_sel    = wr_sel_q;
  assign bus_io.wr_idx    = wr_idx_q;
  assign bus_io.wr_data   = wr_data_q;
  assign bus_io.mul_start = mul_start_q;
  assign bus_io.job_done  = job_done_q;
endmodule

// File: tb/tb_bigmul_operand_loader.sv
// Bench for bigmul_operand_loader: a 64-limb and a 4-limb instance, driven one
// at a time. Expected limb writes are queued as beats are driven and popped as
// writes appear; a small multiplier model answers mul_start with mul_done.
module tb_bigmul_operand_loader;
  localparam int unsigned LW = 64;

  typedef struct packed {
    logic          sel;
    logic [5:0]    idx;
    logic [LW-1:0] data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic          use4       = 1'b0;
  logic          in_valid   = 1'b0;
  logic          in_last    = 1'b0;
  logic [LW-1:0] in_data    = '0;
  logic          busy_force = 1'b0;
  logic          mul_done_m = 1'b0;
  int            mdl_cnt    = 0;
  logic          busy_v;

  assign busy_v = busy_force | (mdl_cnt > 0);

  bigmul_operand_loader_if #(.NUM_LIMBS(64), .LIMB_W(LW)) b64 ();
  bigmul_operand_loader_if #(.NUM_LIMBS(4),  .LIMB_W(LW)) b4 ();

  bigmul_operand_loader #(.NUM_LIMBS(64), .LIMB_W(LW)) u64 (.clk(clk), .rst_n(rst_n), .bus_io(b64.master));
  bigmul_operand_loader #(.NUM_LIMBS(4),  .LIMB_W(LW)) u4  (.clk(clk), .rst_n(rst_n), .bus_io(b4.master));

  assign b64.in_valid = in_valid & ~use4;
  assign b64.in_data  = in_data;
  assign b64.in_last  = in_last;
  assign b64.mul_busy = busy_v & ~use4;
  assign b64.mul_done = mul_done_m & ~use4;
  assign b4.in_valid  = in_valid & use4;
  assign b4.in_data   = in_data;
  assign b4.in_last   = in_last;
  assign b4.mul_busy  = busy_v & use4;
  assign b4.mul_done  = mul_done_m & use4;

  // View of whichever instance is under test
  logic          o_ready, o_wr_en, o_sel, o_start, o_jd;
  logic [5:0]    o_idx;
  logic [LW-1:0] o_data;
  assign o_ready = use4 ? b4.in_ready  : b64.in_ready;
  assign o_wr_en = use4 ? b4.wr_en     : b64.wr_en;
  assign o_sel   = use4 ? b4.wr_sel    : b64.wr_sel;
  assign o_idx   = use4 ? 6'(b4.wr_idx) : b64.wr_idx;
  assign o_data  = use4 ? b4.wr_data   : b64.wr_data;
  assign o_start = use4 ? b4.mul_start : b64.mul_start;
  assign o_jd    = use4 ? b4.job_done  : b64.job_done;

  int vectors = 0, miscompares = 0;
  int wr_cnt = 0, st_cnt = 0, jd_cnt = 0;
  int wr_base = 0, st_base = 0, jd_base = 0;
  int last_wr_cyc = 0, start_cyc = 0, jd_cyc = 0, md_cyc = 0;
  int acc_cyc = 0, n_acc = 0, rdy_bad = 0, nl = 64;
  bit rdy_s = 1'b0, in_job = 1'b0;
  logic [LW-1:0]  op   [64];
  logic [LW-1:0]  mem_a[64];
  logic [LW-1:0]  mem_b[64];
  logic [511:0]   prod = '0;
  logic [255:0]   ref_a, ref_b;
  wr_t            exp_q[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Sampled once per cycle on the falling edge
  task automatic monitor();
    wr_t  e;
    logic got;
    rdy_s      = o_ready;
    mul_done_m = 1'b0;
    if (mdl_cnt > 0) begin
      mdl_cnt--;
      if (mdl_cnt == 0) begin
        mul_done_m = 1'b1;
        md_cyc     = cyc;
      end
    end
    if (o_wr_en) begin
      wr_cnt++;
      last_wr_cyc = cyc;
      if (o_sel) mem_b[o_idx] = o_data;
      else       mem_a[o_idx] = o_data;
      got = (exp_q.size() > 0);
      chk("write_expected", 512'(got), 512'(1));
      if (got) begin
        e = exp_q.pop_front();
        chk("write_sel_idx_data", 512'({o_sel, o_idx, o_data}), 512'(e));
      end
    end
    if (o_start) begin
      st_cnt++;
      start_cyc = cyc;
      chk("start_not_with_write", 512'(o_wr_en), 512'(0));
      chk("start_after_all_writes", 512'(exp_q.size()), 512'(0));
      prod = 512'({mem_a[3], mem_a[2], mem_a[1], mem_a[0]}) *
             512'({mem_b[3], mem_b[2], mem_b[1], mem_b[0]});
      mdl_cnt = 5;
    end
    if (o_jd) begin
      jd_cnt++;
      jd_cyc = cyc;
    end
    if (in_job && o_ready && !o_jd) rdy_bad++;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [LW-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int n = 0; n < 300; n++) begin
      tick();
      if (rdy_s) begin
        acc_cyc = cyc - 1;
        n_acc++;
        break;
      end
    end
  endtask

  task automatic send_operand(input logic sel, input int n, input bit last_flag, input bit gaps);
    wr_t e;
    n_acc = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
      end
      e.sel = sel; e.idx = 6'(i); e.data = op[i];
      exp_q.push_back(e);
      send_beat(op[i], last_flag && (i == n - 1));
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk("beats_accepted", 512'(n_acc), 512'(n));
    if (last_flag) begin
      for (int j = n; j < nl; j++) begin
        e.sel = sel; e.idx = 6'(j); e.data = '0;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic begin_job();
    wr_base = wr_cnt;
    st_base = st_cnt;
    jd_base = jd_cnt;
    rdy_bad = 0;
  endtask

  task automatic finish_job();
    bit seen = 1'b0;
    in_job = 1'b1;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (jd_cnt != jd_base) begin
        seen = 1'b1;
        break;
      end
    end
    in_job = 1'b0;
    chk("job_done_seen", 512'(seen), 512'(1));
    chk("ready_low_during_job", 512'(rdy_bad), 512'(0));
    chk("writes_per_job", 512'(wr_cnt - wr_base), 512'(2 * nl));
    chk("starts_per_job", 512'(st_cnt - st_base), 512'(1));
    chk("job_done_latency", 512'(jd_cyc), 512'(md_cyc + 1));
    chk("scoreboard_drained", 512'(exp_q.size()), 512'(0));
  endtask

  task automatic fill_const(input logic [LW-1:0] d);
    for (int i = 0; i < 64; i++) op[i] = d;
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) op[i] = {$urandom, $urandom};
  endtask

  initial begin
    int  t;
    int  zeros;
    wr_t e;

    // Reset state of both instances
    repeat (3) tick();
    chk("reset_outputs_64", 512'({b64.in_ready, b64.wr_en, b64.wr_sel, b64.wr_idx, b64.wr_data,
                                   b64.mul_start, b64.job_done}), 512'(0));
    chk("reset_outputs_4", 512'({b4.in_ready, b4.wr_en, b4.wr_sel, b4.wr_idx, b4.wr_data,
                                  b4.mul_start, b4.job_done}), 512'(0));
    rst_n = 1'b1;
    tick();
    tick();
    chk("ready_after_reset", 512'(o_ready), 512'(1));

    // Full 64+64 beats, valid held high throughout
    nl = 64;
    begin_job();
    fill_const(64'h7fff_ffff_ffff_ffff);
    send_operand(1'b0, 64, 1'b0, 1'b0);
    send_operand(1'b1, 64, 1'b0, 1'b0);
    t = acc_cyc;
    finish_job();
    chk("full_last_write_cycle", 512'(last_wr_cyc), 512'(t + 1));
    chk("full_start_cycle", 512'(start_cyc), 512'(t + 2));

    // Short A (two limbs) padded with 62 zero writes
    begin_job();
    op[0] = 64'h1;
    op[1] = 64'h1;
    send_operand(1'b0, 2, 1'b1, 1'b0);
    zeros = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (rdy_s) break;
      zeros++;
    end
    chk("pad_a_ready_low_cycles", 512'(zeros), 512'(62));
    fill_rand();
    send_operand(1'b1, 64, 1'b0, 1'b0);
    t = acc_cyc;
    finish_job();
    chk("pad_job_start_cycle", 512'(start_cyc), 512'(t + 2));

    // Reset in the middle of LOAD_B at idx 17
    begin_job();
    fill_rand();
    send_operand(1'b0, 64, 1'b0, 1'b0);
    send_operand(1'b1, 17, 1'b0, 1'b0);
    tick();
    chk("b_writes_before_reset", 512'(exp_q.size()), 512'(0));
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 512'({b64.in_ready, b64.wr_en, b64.wr_sel, b64.wr_idx, b64.wr_data,
                                      b64.mul_start, b64.job_done}), 512'(0));
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("ready_after_mid_job_reset", 512'(o_ready), 512'(1));
    e.sel = 1'b0; e.idx = 6'd0; e.data = 64'hA5A5_5A5A_0F0F_F0F0;
    exp_q.push_back(e);
    send_beat(e.data, 1'b0);
    in_valid = 1'b0;
    tick();
    tick();
    chk("post_reset_writes_a0", 512'(exp_q.size()), 512'(0));

    // Four-limb instance from here on
    use4 = 1'b1;
    nl   = 4;
    tick();

    // Random valid gaps, product checked against reference
    for (int j = 0; j < 2; j++) begin
      begin_job();
      fill_rand();
      ref_a = {op[3], op[2], op[1], op[0]};
      send_operand(1'b0, 4, 1'b0, 1'b1);
      fill_rand();
      ref_b = {op[3], op[2], op[1], op[0]};
      send_operand(1'b1, 4, 1'b0, 1'b1);
      finish_job();
      chk("product_vs_reference", prod, 512'(ref_a) * 512'(ref_b));
    end

    // Busy multiplier on FIRE entry defers the start
    busy_force = 1'b1;
    begin_job();
    fill_rand();
    send_operand(1'b0, 4, 1'b0, 1'b0);
    send_operand(1'b1, 4, 1'b0, 1'b0);
    repeat (10) tick();
    chk("start_held_while_busy", 512'(st_cnt - st_base), 512'(0));
    busy_force = 1'b0;
    t = cyc;
    finish_job();
    chk("start_after_busy_drops", 512'(start_cyc), 512'(t + 1));

    // in_last on the top limb: no padding
    begin_job();
    fill_rand();
    send_operand(1'b0, 4, 1'b1, 1'b0);
    send_operand(1'b1, 4, 1'b1, 1'b0);
    t = acc_cyc;
    finish_job();
    chk("last_on_top_start_cycle", 512'(start_cyc), 512'(t + 2));

    // No in_last on the top limb: operand still ends there
    begin_job();
    fill_rand();
    send_operand(1'b0, 4, 1'b0, 1'b0);
    send_operand(1'b1, 4, 1'b0, 1'b0);
    t = acc_cyc;
    finish_job();
    chk("no_last_top_start_cycle", 512'(start_cyc), 512'(t + 2));

    // Short A and short B both padded on the small instance
    begin_job();
    fill_rand();
    send_operand(1'b0, 1, 1'b1, 1'b0);
    send_operand(1'b1, 3, 1'b1, 1'b0);
    finish_job();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
